// File: rtl/unshift_pkg.sv
// Shared types and helpers for the sequential unshifter: FSM state encoding and the
// width of the shift-amount / counter field.
package unshift_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StShift,
    StDone
  } state_e;

  // Width of a shift amount for a word of n bits; never narrower than one bit.
  function automatic int unsigned sel_w(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/shift_step.sv
// One-bit combinational shift step, left or right, with zero fill or wrap-around.
module shift_step #(
  parameter int unsigned DATA_SIZE = 4,
  parameter int unsigned ROTATION  = 0,
  parameter int unsigned LEFT      = 1
) (
  input  logic [DATA_SIZE-1:0] data_in,
  output logic [DATA_SIZE-1:0] data_out
);

  if (LEFT != 0) begin : g_left
    assign data_out = {data_in[DATA_SIZE-2:0], (ROTATION != 0) ? data_in[DATA_SIZE-1] : 1'b0};
  end else begin : g_right
    assign data_out = {(ROTATION != 0) ? data_in[0] : 1'b0, data_in[DATA_SIZE-1:1]};
  end

endmodule

// File: rtl/seq_unshifter.sv
// Restores a word produced by a barrel shifter by stepping it back one bit per cycle,
// with a valid/ready handshake on both sides.
module seq_unshifter import unshift_pkg::*; #(
  parameter int unsigned DATA_SIZE = 4,
  parameter int unsigned ROTATION  = 0,
  parameter int unsigned DIRECTION = 1
) (
  input  logic                                   clk,
  input  logic                                   rst,
  input  logic                                   in_valid,
  output logic                                   in_ready,
  input  logic [DATA_SIZE-1:0]                   data_in,
  input  logic [unshift_pkg::sel_w(DATA_SIZE)-1:0] select,
  output logic                                   out_valid,
  input  logic                                   out_ready,
  output logic [DATA_SIZE-1:0]                   data_out,
  output logic                                   busy
);

  localparam int unsigned SelW = sel_w(DATA_SIZE);

  state_e                state_q, state_d;
  logic [DATA_SIZE-1:0]  work_q, work_d;
  logic [SelW-1:0]       cnt_q, cnt_d;
  logic [DATA_SIZE-1:0]  stepped;

  // Undoing a right shift means stepping left, and vice versa.
  shift_step #(
    .DATA_SIZE (DATA_SIZE),
    .ROTATION  (ROTATION),
    .LEFT      ((DIRECTION != 0) ? 32'd1 : 32'd0)
  ) u_step (
    .data_in  (work_q),
    .data_out (stepped)
  );

  always_comb begin
    state_d = state_q;
    work_d  = work_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      StIdle: begin
        if (in_valid) begin
          work_d  = data_in;
          cnt_d   = select;
          state_d = (select == '0) ? StDone : StShift;
        end
      end
      StShift: begin
        work_d = stepped;
        cnt_d  = cnt_q - SelW'(1);
        if (cnt_q <= SelW'(1)) begin
          state_d = StDone;
        end
      end
      StDone: begin
        if (out_ready) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      work_q  <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      work_q  <= work_d;
      cnt_q   <= cnt_d;
    end
  end

  assign in_ready  = (state_q == StIdle);
  assign out_valid = (state_q == StDone);
  assign busy      = (state_q != StIdle);
  assign data_out  = work_q;

endmodule

// File: doc/seq_unshifter.md
SEQ_UNSHIFTER -- requirements
Module: seq_unshifter

Interface
REQ-001 SHALL have parameter DATA_SIZE, default 4, data word width in bits (>=2).
REQ-002 SHALL have parameter ROTATION, default 0, 1 = forward shifter rotated, 0 = forward shifter was logical.
REQ-003 SHALL have parameter DIRECTION, default 1, direction of the forward shifter being undone: 1 = right, 0 = left.
REQ-004 SHALL have port clk  input  1  single clock, all state updates on rising edge.
REQ-005 SHALL have port rst  input  1  synchronous reset, active-high.
REQ-006 SHALL have port in_valid  input  1  data_in/select valid.
REQ-007 SHALL have port in_ready  output  1  block can accept a word.
REQ-008 SHALL have port data_in  input  DATA_SIZE  shifted word to be restored.
REQ-009 SHALL have port select  input  SEL_W=$clog2(DATA_SIZE)  shift amount applied by the forward shifter.
REQ-010 SHALL have port out_valid  output  1  data_out holds a restored word.
REQ-011 SHALL have port out_ready  input  1  consumer accepts data_out.
REQ-012 SHALL have port data_out  output  DATA_SIZE  restored word.
REQ-013 SHALL have port busy  output  1  high in any state other than IDLE.

Function
REQ-014 SHALL implement FSM states IDLE, SHIFT, DONE.
REQ-015 SHALL assert in_ready only in IDLE; accept occurs on an edge with in_valid=1 and in_ready=1.
REQ-016 On accept, SHALL load work register <= data_in and counter <= select; next state DONE if select==0, otherwise SHIFT.
REQ-017 In SHIFT, SHALL apply exactly one 1-bit step per cycle opposite to DIRECTION (DIRECTION=1 -> step left; DIRECTION=0 -> step right) and decrement counter; go to DONE on the step taken with counter==1.
REQ-018 Step with ROTATION=1 SHALL wrap the exiting bit into the vacated end; with ROTATION=0 SHALL fill the vacated end with 0.
REQ-019 out_valid SHALL be 1 exactly in DONE; first visible select+1 cycles after the accept edge.
REQ-020 data_out SHALL equal the work register at all times and SHALL stay stable while out_valid=1 and out_ready=0.
REQ-021 In DONE, out_ready=1 SHALL return the FSM to IDLE on that edge; no new word accepted on that same edge (in_ready=0 in DONE).
REQ-022 in_valid while not in IDLE SHALL be ignored; data_in/select changes outside accept SHALL not affect the result.
REQ-023 Counter width SHALL be SEL_W; select of all ones SHALL produce DATA_SIZE-1 steps with no counter wrap.

Reset
REQ-024 rst=1 on a clock edge SHALL force state IDLE, work register 0, counter 0, regardless of state, including mid-SHIFT and DONE.
REQ-025 During/after reset: in_ready=1, out_valid=0, busy=0, data_out=0.
REQ-026 rst SHALL take priority over accept and over out_ready handshake on the same edge.

Structure
REQ-027 State enum (IDLE/SHIFT/DONE) SHALL reside in shared package unshift_pkg, together with a SEL_W width helper function.
REQ-028 The 1-bit step SHALL be a combinational sub-module shift_step (parameters DATA_SIZE, ROTATION, LEFT), instantiated once.
REQ-029 All outputs SHALL be driven from registers or state decode only; no combinational path from in_valid/out_ready to outputs other than none.

Verification
REQ-030 DATA_SIZE=4, ROTATION=0, DIRECTION=1: data_in 4'b0011, select 2 -> out_valid 3 cycles after accept, data_out 4'b1100.
REQ-031 ROTATION=1, DIRECTION=0: data_in 4'b1001, select 1 -> data_out 4'b1100 after 2 cycles; select 3 on 4'b1001 -> 4'b0011 (wrap).
REQ-032 select 0, data_in 4'b1010 -> out_valid next cycle, data_out 4'b1010, busy high 1 cycle.
REQ-033 Backpressure: out_ready=0 for 5 cycles in DONE -> data_out and out_valid stable, in_ready=0, new in_valid ignored; out_ready=1 -> IDLE next cycle.
REQ-034 rst=1 during SHIFT (select 3, after 1 step) -> next cycle IDLE, data_out 0, out_valid 0, in_ready 1; following accept completes normally.
REQ-035 Round-trip: random data/select through forward shifter model then this block, all 16x4 combos -> rotation exact match; logical matches with lost bits zero.
